logic_unit_arbiter: RTL
=======================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Block SHALL have no parameters; datapath width fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 presents an operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op SHALL mirror REQ-004..007 for requester 1.
REQ-009 res_valid  output  1  result register holds a valid result.
REQ-010 res_ready  input  1  consumer takes result this cycle.
REQ-011 res_data  output  32  registered bitwise result.
REQ-012 res_id  output  1  index of requester that produced res_data.

Function
REQ-013 FSM SHALL have two states: EMPTY (res_valid=0) and FULL (res_valid=1); res_valid is the state.
REQ-014 can_accept SHALL be (state==EMPTY) or (res_ready==1).
REQ-015 Grant: if exactly one reqN_valid, grant it; if both, grant requester other than last_grant; if none, no grant.
REQ-016 reqN_ready SHALL be combinational: 1 only when N is granted and can_accept=1; never both high.
REQ-017 Acceptance (valid & ready) SHALL load res_data = op(a,b) bitwise per REQ-007, res_id = N, res_valid=1 on next edge; latency exactly 1 cycle.
REQ-018 last_grant SHALL update to N only on acceptance; unchanged when no transfer.
REQ-019 FULL with res_ready=1 and no acceptance -> EMPTY; FULL with res_ready=1 and acceptance -> FULL with new result (back-to-back, full throughput).
REQ-020 FULL with res_ready=0: res_data, res_id, res_valid SHALL hold stable; all reqN_ready=0.
REQ-021 Requester dropping valid before acceptance SHALL not change last_grant.
REQ-022 res_ready while EMPTY SHALL have no effect.

Reset
REQ-023 reset SHALL immediately force res_valid=0, res_data=0, res_id=0, last_grant=1 (requester 0 wins first tie), state EMPTY.
REQ-024 reset asserted mid-operation SHALL discard any held result; no transfer completes in a cycle with reset high.

Configuration
REQ-025 With macro LOGIC_ARB_GRANT_CNT_EN defined, block SHALL add outputs grant_cnt0, grant_cnt1 (16 bits each) counting acceptances per requester, saturating at 16'hFFFF, reset to 0.
REQ-026 Without LOGIC_ARB_GRANT_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-027 Reset, then req0 only: a=32'hF0F0_F0F0, b=32'h0FF0_0FF0, op=00, res_ready=1 -> next cycle res_valid=1, res_data=32'h00F0_00F0, res_id=0.
REQ-028 Both valid continuously, res_ready=1 -> grants alternate 0,1,0,1; one result per cycle; res_id alternates.
REQ-029 Result FULL, res_ready=0 for 3 cycles with both valid -> both ready=0, res_data stable; res_ready=1 -> next grant accepted same cycle.
REQ-030 op sweep with a=32'hFFFF_0000, b=32'hFF00_FF00 -> AND 32'hFF00_0000, OR 32'hFFFF_FF00, XOR 32'h00FF_FF00, NOR 32'h0000_00FF.
REQ-031 reset pulsed while res_valid=1 -> res_valid=0 and res_data=0 immediately (before next clk edge); next tie grants requester 0.
REQ-032 With LOGIC_ARB_GRANT_CNT_EN: 5 req1 acceptances -> grant_cnt1=5, grant_cnt0=0; counter preloaded to 16'hFFFF stays at 16'hFFFF on further grants.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin bitwise logic unit (AND/OR/XOR/NOR) with one result register; LOGIC_ARB_GRANT_CNT_EN adds per-requester grant counters.
// Latency: result visible exactly 1 cycle after acceptance; full throughput when the consumer keeps res_ready high.
// Backpressure: reqN_ready is combinational and drops whenever the result register is full and res_ready is low.
module logic_unit_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_op,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_id
`ifdef LOGIC_ARB_GRANT_CNT_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        gnt_vld;
  logic        gnt_id;
  logic        can_accept;
  logic        accept;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [1:0]  sel_op;
  logic [31:0] op_result;

  function automatic logic [31:0] bit_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = ~last_grant;
    end else if (req0_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b0;
    end else if (req1_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  always_comb begin
    sel_a     = gnt_id ? req1_a  : req0_a;
    sel_b     = gnt_id ? req1_b  : req0_b;
    sel_op    = gnt_id ? req1_op : req0_op;
    op_result = bit_op(sel_a, sel_b, sel_op);
  end

  // Gating with reset keeps any handshake from completing while reset is held.
  always_comb begin
    state_nxt  = state;
    can_accept = ~reset & ((state == EMPTY) | res_ready);
    accept     = gnt_vld & can_accept;
    req0_ready = accept & ~gnt_id;
    req1_ready = accept & gnt_id;
    if (accept) begin
      state_nxt = FULL;
    end else if (state == FULL && res_ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data   <= 32'd0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      res_data   <= op_result;
      res_id     <= gnt_id;
      last_grant <= gnt_id;
    end
  end

  assign res_valid = (state == FULL);

`ifdef LOGIC_ARB_GRANT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else begin
      if (req0_ready && req0_valid && grant_cnt0 != 16'hFFFF) begin
        grant_cnt0 <= grant_cnt0 + 16'd1;
      end
      if (req1_ready && req1_valid && grant_cnt1 != 16'hFFFF) begin
        grant_cnt1 <= grant_cnt1 + 16'd1;
      end
    end
  end
`else
  // Grant counters are compiled out in this build.
`endif

endmodule
